// File: rtl/frame_header_decoder_ext.sv
// Frame header decoder: walks a circular frame store from the buffer tail,
// captures EID/length/extension words, tracks payload use, releases the tail.
module frame_header_decoder_ext #(
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 9,
    parameter int          EXT_WORDS = 0,
    parameter logic [31:0] FRAG_CODE = 32'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W:0]       in_frame_data,
    input  logic                  in_frame_valid,
    input  logic                  in_frame_data_valid,
    input  logic [ADDR_W-1:0]     in_frame_tail,
    input  logic                  in_frame_next,
    input  logic                  header_done_clear,
    output logic [ADDR_W-1:0]     in_frame_addr,
    output logic                  in_frame_latch_tail,
    output logic [DATA_W-1:0]     header_eid,
    output logic [DATA_W-1:0]     header_len,
    output logic [((EXT_WORDS > 0) ? EXT_WORDS : 1)*DATA_W-1:0] header_ext,
    output logic                  header_done,
    output logic                  packet_is_empty,
    output logic                  is_fragment,
    output logic [ADDR_W-1:0]     payload_count,
    output logic                  len_error,
    output logic                  hdr_truncated,
    output logic                  frame_end
);

    localparam int EXT_N = (EXT_WORDS > 0) ? EXT_WORDS : 1;
    localparam int IDX_W = 3;
    localparam int CMP_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam logic [DATA_W-1:0] FRAG = FRAG_CODE[DATA_W-1:0];
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        EID,
        LEN,
        EXT,
        WAIT,
        TAIL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0] eid_q, eid_d;
    logic [DATA_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] ext_q [EXT_N];
    logic [DATA_W-1:0] ext_d [EXT_N];
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              empty_q, empty_d;
    logic              frag_q, frag_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              lerr_q, lerr_d;
    logic              trunc_q, trunc_d;

    logic              adv;
    logic              eof;
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] cnt_inc;
    logic [ADDR_W-1:0] cnt_fin;
    logic [CMP_W-1:0]  cmp_cnt;
    logic [CMP_W-1:0]  cmp_len;

    assign word = in_frame_data[DATA_W-1:0];
    assign eof  = in_frame_data[DATA_W];

    assign cnt_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign cnt_fin = in_frame_next ? cnt_inc : count_q;
    assign cmp_cnt = CMP_W'(cnt_fin);
    assign cmp_len = CMP_W'(len_q);

    always_comb begin
        state_d = state_q;
        eid_d   = eid_q;
        len_d   = len_q;
        ext_d   = ext_q;
        idx_d   = idx_q;
        done_d  = done_q;
        empty_d = empty_q;
        frag_d  = frag_q;
        count_d = count_q;
        lerr_d  = lerr_q;
        trunc_d = trunc_q;
        adv     = 1'b0;

        // a same-cycle set below overrides the acknowledge
        if (header_done_clear) begin
            done_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (in_frame_valid) begin
                    adv     = 1'b1;
                    lerr_d  = 1'b0;
                    trunc_d = 1'b0;
                    count_d = '0;
                    idx_d   = '0;
                    state_d = EID;
                end
            end
            EID: begin
                if (in_frame_data_valid) begin
                    adv = 1'b1;
                    if (eof) begin
                        trunc_d = 1'b1;
                        state_d = TAIL;
                    end else begin
                        eid_d   = word;
                        state_d = LEN;
                    end
                end
            end
            LEN: begin
                if (in_frame_data_valid) begin
                    adv = 1'b1;
                    if (eof) begin
                        trunc_d = 1'b1;
                        state_d = TAIL;
                    end else begin
                        len_d   = word;
                        frag_d  = (word == FRAG);
                        empty_d = (word == '0);
                        if (EXT_WORDS == 0) begin
                            done_d  = 1'b1;
                            state_d = WAIT;
                        end else begin
                            state_d = EXT;
                        end
                    end
                end
            end
            EXT: begin
                if (in_frame_data_valid) begin
                    adv = 1'b1;
                    if (eof) begin
                        trunc_d = 1'b1;
                        state_d = TAIL;
                    end else begin
                        for (int i = 0; i < EXT_N; i++) begin
                            if (int'(idx_q) == i) begin
                                ext_d[i] = word;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                        if (int'(idx_q) == EXT_WORDS - 1) begin
                            done_d  = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (in_frame_next) begin
                    count_d = cnt_inc;
                end
                if (in_frame_data_valid && eof) begin
                    adv     = 1'b1;
                    state_d = TAIL;
                    if (!frag_q && (cmp_cnt != cmp_len)) begin
                        lerr_d = 1'b1;
                    end
                end
            end
            TAIL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // the reader's consumption moves the window even outside WAIT
    always_comb begin
        if (state_q == IDLE) begin
            offset_d = '0;
        end else begin
            offset_d = offset_q + ADDR_W'(adv) + ADDR_W'(in_frame_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            offset_q <= '0;
            eid_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            empty_q  <= 1'b0;
            frag_q   <= 1'b0;
            count_q  <= '0;
            lerr_q   <= 1'b0;
            trunc_q  <= 1'b0;
            for (int i = 0; i < EXT_N; i++) begin
                ext_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            eid_q    <= eid_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            empty_q  <= empty_d;
            frag_q   <= frag_d;
            count_q  <= count_d;
            lerr_q   <= lerr_d;
            trunc_q  <= trunc_d;
            for (int i = 0; i < EXT_N; i++) begin
                ext_q[i] <= ext_d[i];
            end
        end
    end

    always_comb begin
        header_ext = '0;
        if (EXT_WORDS > 0) begin
            for (int i = 0; i < EXT_N; i++) begin
                header_ext[i*DATA_W +: DATA_W] = ext_q[i];
            end
        end
    end

    assign in_frame_addr       = in_frame_tail + offset_q;
    assign in_frame_latch_tail = (state_q == TAIL);
    assign frame_end           = (state_q == TAIL);
    assign header_eid          = eid_q;
    assign header_len          = len_q;
    assign header_done         = done_q;
    assign packet_is_empty     = empty_q;
    assign is_fragment         = frag_q;
    assign payload_count       = count_q;
    assign len_error           = lerr_q;
    assign hdr_truncated       = trunc_q;

endmodule
